// File: rtl/fixed_encoder_pipe.sv
// ---------------------------------------------------------------------------
// fixed_encoder_pipe
//
// Fixed-polynomial predictor front end for a lossless audio encoder. Each
// accepted PCM sample is turned into a residual of the requested fixed order
// (0..4), and the absolute residuals of every order are accumulated across
// the frame. At frame end the cheapest order is reported.
//
// Ports
//   iClock       in   1   clock, rising edge
//   iReset       in   1   synchronous active-high reset, highest priority
//   iEnable      in   1   iSample is valid this cycle
//   iFrameStart  in   1   first sample of a new frame; clears history/count/sums
//   iFrameEnd    in   1   last cycle of the frame; request best-order decision
//   iOrder       in   4   predictor order for oResidual (5..15 behave as 4)
//   iSample      in  16   signed PCM sample
//   oResidual    out 20   signed residual, or sign-extended sample in warmup
//   oValid       out  1   one-cycle pulse: oResidual/oWarmup updated
//   oWarmup      out  1   oResidual carries the verbatim sample
//   oBestOrder   out  3   order with the smallest absolute-residual sum
//   oBestValid   out  1   one-cycle pulse: oBestOrder updated
// ---------------------------------------------------------------------------
module fixed_encoder_pipe (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iEnable,
    input  logic               iFrameStart,
    input  logic               iFrameEnd,
    input  logic [3:0]         iOrder,
    input  logic signed [15:0] iSample,
    output logic signed [19:0] oResidual,
    output logic               oValid,
    output logic               oWarmup,
    output logic [2:0]         oBestOrder,
    output logic               oBestValid
);

    localparam int NUM_ORDERS = 5;
    localparam int HIST_DEPTH = 4;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // hist_q[0] is x1 (most recent accepted sample) ... hist_q[3] is x4.
    logic signed [15:0] hist_q [HIST_DEPTH];
    logic signed [15:0] hist_d [HIST_DEPTH];
    logic [2:0]         n_q;
    logic [2:0]         n_d;
    logic [31:0]        acc_q  [NUM_ORDERS];
    logic [31:0]        acc_d  [NUM_ORDERS];

    logic signed [19:0] residual_q;
    logic signed [19:0] residual_d;
    logic               valid_q;
    logic               valid_d;
    logic               warmup_q;
    logic               warmup_d;
    logic [2:0]         best_order_q;
    logic [2:0]         best_order_d;
    logic               best_valid_q;
    logic               best_valid_d;

    // -----------------------------------------------------------------------
    // Frame-start view of the state: a sample arriving together with
    // iFrameStart must see an empty history, so the clear is applied
    // combinationally before the datapath rather than one cycle later.
    // -----------------------------------------------------------------------
    logic signed [15:0] hist_eff [HIST_DEPTH];
    logic [2:0]         n_eff;
    logic [31:0]        acc_base [NUM_ORDERS];

    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_eff
            assign hist_eff[gi] = iFrameStart ? 16'sd0 : hist_q[gi];
        end
    endgenerate

    assign n_eff = iFrameStart ? 3'd0 : n_q;

    // -----------------------------------------------------------------------
    // Fixed predictors. All operands are widened to 20 bits first; the worst
    // case magnitude of e4 is 16 * 32768 minus a little, which fits.
    // -----------------------------------------------------------------------
    logic signed [19:0] x0_ext;
    logic signed [19:0] x_ext [HIST_DEPTH];
    logic signed [19:0] e     [NUM_ORDERS];

    assign x0_ext = 20'(iSample);

    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_ext
            assign x_ext[gi] = 20'(hist_eff[gi]);
        end
    endgenerate

    always_comb begin
        e[0] = x0_ext;
        e[1] = x0_ext - x_ext[0];
        e[2] = x0_ext - 20'sd2 * x_ext[0] + x_ext[1];
        e[3] = x0_ext - 20'sd3 * x_ext[0] + 20'sd3 * x_ext[1] - x_ext[2];
        e[4] = x0_ext - 20'sd4 * x_ext[0] + 20'sd6 * x_ext[1]
                      - 20'sd4 * x_ext[2] + x_ext[3];
    end

    // -----------------------------------------------------------------------
    // Order selection and warmup decision for the output residual.
    // -----------------------------------------------------------------------
    logic [2:0] order_eff;
    logic       in_warmup;

    assign order_eff = (iOrder > 4'd4) ? 3'd4 : iOrder[2:0];
    assign in_warmup = (n_eff < order_eff);

    // -----------------------------------------------------------------------
    // Absolute-residual accumulators. Only samples with a full history are
    // added, so every order is scored over exactly the same sample set.
    // -----------------------------------------------------------------------
    logic acc_update;
    assign acc_update = iEnable && (n_eff == 3'd4);

    generate
        for (genvar gi = 0; gi < NUM_ORDERS; gi++) begin : g_acc
            logic [19:0] mag;
            logic [32:0] sum;

            assign mag         = e[gi][19] ? $unsigned(-e[gi]) : $unsigned(e[gi]);
            assign acc_base[gi] = iFrameStart ? 32'd0 : acc_q[gi];
            assign sum         = {1'b0, acc_base[gi]} + {13'd0, mag};
            // Carry out of bit 31 means the sum passed 2^32-1: clamp.
            assign acc_d[gi]   = !acc_update ? acc_base[gi]
                               : (sum[32] ? 32'hFFFF_FFFF : sum[31:0]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Best-order search. A frame end that coincides with a frame start scores
    // the old frame as it stood before this cycle; otherwise the current
    // sample (if any) is included. Strict less-than keeps the lowest index on
    // ties, so an all-equal set (including all zero) yields order 0.
    // -----------------------------------------------------------------------
    logic [31:0] cmp_val [NUM_ORDERS];
    logic [2:0]  best_idx;
    logic [31:0] best_val;

    generate
        for (genvar gi = 0; gi < NUM_ORDERS; gi++) begin : g_cmp
            assign cmp_val[gi] = iFrameStart ? acc_q[gi] : acc_d[gi];
        end
    endgenerate

    always_comb begin
        best_idx = 3'd0;
        best_val = cmp_val[0];
        for (int k = 1; k < NUM_ORDERS; k++) begin
            if (cmp_val[k] < best_val) begin
                best_val = cmp_val[k];
                best_idx = 3'(k);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic for history, count and output registers.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < HIST_DEPTH; k++) begin
            hist_d[k] = hist_eff[k];
        end
        n_d          = n_eff;
        residual_d   = residual_q;
        warmup_d     = warmup_q;
        valid_d      = 1'b0;
        best_order_d = best_order_q;
        best_valid_d = 1'b0;

        if (iEnable) begin
            hist_d[0] = iSample;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_d[k] = hist_eff[k-1];
            end
            n_d        = (n_eff == 3'd4) ? 3'd4 : n_eff + 3'd1;
            valid_d    = 1'b1;
            warmup_d   = in_warmup;
            residual_d = in_warmup ? x0_ext : e[order_eff];
        end

        if (iFrameEnd) begin
            best_order_d = best_idx;
            best_valid_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers. Reset wins over everything, which also swallows a frame-end
    // request presented on the reset cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_q[k] <= 16'sd0;
            end
            for (int k = 0; k < NUM_ORDERS; k++) begin
                acc_q[k] <= 32'd0;
            end
            n_q          <= 3'd0;
            residual_q   <= 20'sd0;
            valid_q      <= 1'b0;
            warmup_q     <= 1'b0;
            best_order_q <= 3'd0;
            best_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_q[k] <= hist_d[k];
            end
            for (int k = 0; k < NUM_ORDERS; k++) begin
                acc_q[k] <= acc_d[k];
            end
            n_q          <= n_d;
            residual_q   <= residual_d;
            valid_q      <= valid_d;
            warmup_q     <= warmup_d;
            best_order_q <= best_order_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign oResidual  = residual_q;
    assign oValid     = valid_q;
    assign oWarmup    = warmup_q;
    assign oBestOrder = best_order_q;
    assign oBestValid = best_valid_q;

endmodule

// File: tb/tb_fixed_encoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_fixed_encoder_pipe
//
// Table-driven directed vectors, hand-written multi-cycle sequences, and a
// randomized phase compared against a behavioural model built from the
// binomial definition of the fixed predictors.
// ---------------------------------------------------------------------------
module tb_fixed_encoder_pipe;

    logic               clk;
    logic               iReset;
    logic               iEnable;
    logic               iFrameStart;
    logic               iFrameEnd;
    logic [3:0]         iOrder;
    logic signed [15:0] iSample;
    logic signed [19:0] oResidual;
    logic               oValid;
    logic               oWarmup;
    logic [2:0]         oBestOrder;
    logic               oBestValid;

    fixed_encoder_pipe dut (
        .iClock      (clk),
        .iReset      (iReset),
        .iEnable     (iEnable),
        .iFrameStart (iFrameStart),
        .iFrameEnd   (iFrameEnd),
        .iOrder      (iOrder),
        .iSample     (iSample),
        .oResidual   (oResidual),
        .oValid      (oValid),
        .oWarmup     (oWarmup),
        .oBestOrder  (oBestOrder),
        .oBestValid  (oBestValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    int     m_hist [4];   // m_hist[j-1] = x_j
    int     m_n;
    longint m_sum [5];
    int     m_res;
    bit     m_valid;
    bit     m_warm;
    int     m_best;
    bit     m_bvalid;

    function automatic int binom(input int k, input int j);
        int r = 1;
        for (int i = 0; i < j; i++) r = r * (k - i) / (i + 1);
        return r;
    endfunction

    // k-th backward difference of the sample sequence.
    function automatic int fixed_pred(input int k, input int x);
        int r = x;
        for (int j = 1; j <= k; j++) begin
            r += ((j % 2) ? -1 : 1) * binom(k, j) * m_hist[j-1];
        end
        return r;
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit fs,
                              input bit fe, input int ord, input int smp);
        longint old_sum [5];
        longint cmp [5];
        int     e [5];
        int     o;
        if (rst) begin
            foreach (m_hist[j]) m_hist[j] = 0;
            foreach (m_sum[j])  m_sum[j]  = 0;
            m_n = 0; m_res = 0; m_valid = 0; m_warm = 0; m_best = 0; m_bvalid = 0;
            return;
        end
        old_sum = m_sum;
        if (fs) begin
            foreach (m_hist[j]) m_hist[j] = 0;
            foreach (m_sum[j])  m_sum[j]  = 0;
            m_n = 0;
        end
        m_valid  = 0;
        m_bvalid = 0;
        if (en) begin
            o = (ord > 4) ? 4 : ord;
            for (int k = 0; k < 5; k++) e[k] = fixed_pred(k, smp);
            m_valid = 1;
            m_warm  = (m_n < o);
            m_res   = m_warm ? smp : e[o];
            if (m_n == 4) begin
                for (int k = 0; k < 5; k++) begin
                    m_sum[k] += (e[k] < 0) ? -e[k] : e[k];
                    if (m_sum[k] > 64'hFFFF_FFFF) m_sum[k] = 64'hFFFF_FFFF;
                end
            end
            for (int j = 3; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = smp;
            if (m_n < 4) m_n++;
        end
        if (fe) begin
            cmp = fs ? old_sum : m_sum;
            m_best = 0;
            for (int k = 1; k < 5; k++) if (cmp[k] < cmp[m_best]) m_best = k;
            m_bvalid = 1;
        end
    endtask

    // Drive one cycle of inputs on the falling edge, sample #1 after rise.
    task automatic apply(input bit rst, input bit en, input bit fs, input bit fe,
                         input logic [3:0] ord, input logic signed [15:0] smp);
        @(negedge clk);
        iReset = rst; iEnable = en; iFrameStart = fs; iFrameEnd = fe;
        iOrder = ord; iSample = smp;
        model_step(rst, en, fs, fe, int'(ord), int'(smp));
        @(posedge clk);
        #1;
        $display("txn rst=%0b en=%0b fs=%0b fe=%0b ord=%0d smp=%0d -> res=%0d v=%0b w=%0b best=%0d bv=%0b",
                 rst, en, fs, fe, ord, smp, oResidual, oValid, oWarmup, oBestOrder, oBestValid);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".res"},    oResidual,  m_res);
        chk({tag, ".valid"},  oValid,     m_valid);
        chk({tag, ".warm"},   oWarmup,    m_warm);
        chk({tag, ".best"},   oBestOrder, m_best);
        chk({tag, ".bvalid"}, oBestValid, m_bvalid);
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic               fs;
        logic [3:0]         ord;
        logic signed [15:0] smp;
        logic signed [19:0] exp_res;
        logic               exp_warm;
    } vec_t;

    vec_t tbl [$];

    initial begin
        iReset = 1'b0; iEnable = 1'b0; iFrameStart = 1'b0; iFrameEnd = 1'b0;
        iOrder = 4'd0; iSample = 16'sd0;

        // Order 2 ramp: two verbatim warmup samples, then exact prediction.
        tbl.push_back('{1'b1, 4'd2, 16'sd10, 20'sd10, 1'b1});
        tbl.push_back('{1'b0, 4'd2, 16'sd20, 20'sd20, 1'b1});
        tbl.push_back('{1'b0, 4'd2, 16'sd30, 20'sd0,  1'b0});
        tbl.push_back('{1'b0, 4'd2, 16'sd40, 20'sd0,  1'b0});
        tbl.push_back('{1'b0, 4'd2, 16'sd50, 20'sd0,  1'b0});
        // Order 4 on squares: third difference constant, fourth is zero.
        tbl.push_back('{1'b1, 4'd4, 16'sd0,  20'sd0,  1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sd1,  20'sd1,  1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sd4,  20'sd4,  1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sd9,  20'sd9,  1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sd16, 20'sd0,  1'b0});
        tbl.push_back('{1'b0, 4'd4, 16'sd25, 20'sd0,  1'b0});
        // Full-scale alternation: order 4 residual peaks without wrapping.
        tbl.push_back('{1'b1, 4'd4, 16'sh7FFF, 20'sd32767,  1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sh8000, -20'sd32768, 1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sh7FFF, 20'sd32767,  1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sh8000, -20'sd32768, 1'b1});
        tbl.push_back('{1'b0, 4'd4, 16'sh7FFF, 20'sd524280, 1'b0});
        // Orders above 4 behave as 4 (warmup judged against order 4).
        tbl.push_back('{1'b1, 4'd15, 16'sd5, 20'sd5, 1'b1});
        tbl.push_back('{1'b0, 4'd9,  16'sd6, 20'sd6, 1'b1});
        // Negative sample in warmup is sign-extended.
        tbl.push_back('{1'b1, 4'd1, -16'sd123, -20'sd123, 1'b1});
        tbl.push_back('{1'b0, 4'd1, -16'sd200, -20'sd77,  1'b0});

        // Reset state.
        apply(1, 0, 0, 0, 4'd0, 16'sd0);
        apply(1, 0, 0, 0, 4'd0, 16'sd0);
        chk("rst.res", oResidual, 0);
        chk("rst.valid", oValid, 0);
        chk("rst.warm", oWarmup, 0);
        chk("rst.best", oBestOrder, 0);
        chk("rst.bvalid", oBestValid, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(0, 1, tbl[i].fs, 0, tbl[i].ord, tbl[i].smp);
            chk($sformatf("vec%0d.res", i), oResidual, tbl[i].exp_res);
            chk($sformatf("vec%0d.warm", i), oWarmup, tbl[i].exp_warm);
            chk($sformatf("vec%0d.valid", i), oValid, 1);
        end

        // Constant frame: order 0 sum 600, orders 1..4 zero -> best is 1.
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, (i == 0), (i == 9), 4'd0, 16'sd100);
        end
        chk("const.bvalid", oBestValid, 1);
        chk("const.best", oBestOrder, 1);
        chk("const.res", oResidual, 100);
        // Idle cycle: single pulse, outputs hold.
        apply(0, 0, 0, 0, 4'd3, 16'sd999);
        chk("idle.bvalid", oBestValid, 0);
        chk("idle.best", oBestOrder, 1);
        chk("idle.valid", oValid, 0);
        chk("idle.res", oResidual, 100);
        chk("idle.warm", oWarmup, 0);

        // Empty frame end: all sums zero -> order 0.
        apply(0, 0, 1, 0, 4'd0, 16'sd0);
        apply(0, 0, 0, 1, 4'd0, 16'sd0);
        chk("empty.bvalid", oBestValid, 1);
        chk("empty.best", oBestOrder, 0);

        // Mid-frame reset, then a fresh sample is warmup.
        apply(0, 1, 1, 0, 4'd1, 16'sd5);
        apply(0, 1, 0, 0, 4'd1, 16'sd6);
        apply(0, 1, 0, 0, 4'd1, 16'sd9);
        apply(1, 0, 0, 0, 4'd1, 16'sd0);
        chk("midrst.res", oResidual, 0);
        chk("midrst.valid", oValid, 0);
        chk("midrst.warm", oWarmup, 0);
        apply(0, 1, 0, 0, 4'd1, 16'sd7);
        chk("post.res", oResidual, 7);
        chk("post.warm", oWarmup, 1);
        chk("post.valid", oValid, 1);

        // Reset coinciding with frame end suppresses the decision.
        apply(1, 1, 0, 1, 4'd1, 16'sd3);
        chk("rstfe.bvalid", oBestValid, 0);

        // Ramp frame then start+end+sample on one cycle: decision from the
        // old frame (sums 220,40,0,0,0 -> 2), sample starts new frame.
        for (int i = 0; i < 8; i++) begin
            apply(0, 1, (i == 0), 0, 4'd1, 16'(i * 10));
        end
        apply(0, 1, 1, 1, 4'd3, 16'sd500);
        chk("sfe.bvalid", oBestValid, 1);
        chk("sfe.best", oBestOrder, 2);
        chk("sfe.res", oResidual, 500);
        chk("sfe.warm", oWarmup, 1);

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            logic signed [15:0] s;
            int mode = $urandom_range(0, 3);
            if (mode == 0)      s = ($urandom_range(0, 1) != 0) ? 16'sh7FFF : 16'sh8000;
            else if (mode == 1) s = 16'($signed($urandom_range(0, 64)) - 32);
            else                s = 16'($urandom);
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0),
                  4'($urandom_range(0, 15)), s);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_encoder_pipe.md
FIXED_ENCODER_PIPE -- requirements
Module: fixed_encoder_pipe

Interface
REQ-001 SHALL have no parameters; widths fixed: sample 16 b signed, residual 20 b signed, accumulator 32 b unsigned.
REQ-002 iClock  in  1  clock; all state updates on rising edge.
REQ-003 iReset  in  1  synchronous, active-high reset.
REQ-004 iEnable  in  1  iSample valid this cycle.
REQ-005 iFrameStart  in  1  first sample of new frame; clears history, count, accumulators.
REQ-006 iFrameEnd  in  1  last cycle of frame; requests order selection.
REQ-007 iOrder  in  4  fixed-predictor order for oResidual; legal 0..4; 5..15 treated as 4.
REQ-008 iSample  in  16  signed PCM sample.
REQ-009 oResidual  out  20  signed residual, or sign-extended verbatim sample during warmup.
REQ-010 oValid  out  1  one-cycle pulse, oResidual/oWarmup valid.
REQ-011 oWarmup  out  1  oResidual is a verbatim warmup sample.
REQ-012 oBestOrder  out  3  order 0..4 with minimum absolute-residual sum.
REQ-013 oBestValid  out  1  one-cycle pulse, oBestOrder valid.

Function
REQ-014 SHALL keep history x1..x4 (previous four accepted samples) and sample count n, saturating at 4.
REQ-015 On iEnable: shift history (x4<=x3 ... x1<=iSample); n<=n+1 until saturated.
REQ-016 SHALL compute, in 20-bit signed arithmetic with operands sign-extended before any operation: e0=x; e1=x-x1; e2=x-2x1+x2; e3=x-3x1+3x2-x3; e4=x-4x1+6x2-4x3+x4. No overflow is possible for any 16-bit input.
REQ-017 Latency: oResidual, oWarmup, oValid SHALL be registered and appear exactly 1 cycle after the iEnable cycle.
REQ-018 If n < effective order: oResidual = sign-extended iSample, oWarmup=1; else oResidual = e[effective order], oWarmup=0.
REQ-019 Cycle without iEnable: oValid=0; oResidual and oWarmup hold previous values; history, n unchanged.
REQ-020 iOrder MAY change on any cycle; it applies to that cycle's sample only, and warmup is judged against current n.
REQ-021 Five accumulators S0..S4 SHALL add |e_k| on each iEnable cycle with n==4 (before increment), so all orders are compared over identical samples; each saturates at 2^32-1.
REQ-022 iFrameStart (with or without iEnable): history, n, S0..S4 cleared; a sample on the same cycle is processed as sample 0 of the new frame (verbatim warmup for any order >=1).
REQ-023 iFrameEnd: next cycle oBestValid=1 for one cycle, oBestOrder = index of minimum S_k; ties resolved to lowest index; all S_k equal (incl. no accumulated samples) -> 0.
REQ-024 iFrameEnd with iEnable (no iFrameStart): current sample is included in the comparison.
REQ-025 iFrameEnd with iFrameStart: comparison uses accumulators before this cycle (current sample excluded), then clear per REQ-022 applies.
REQ-026 oBestOrder SHALL hold between pulses.
REQ-027 Block SHALL accept one sample per cycle with no stall; no backpressure.

Reset
REQ-028 iReset SHALL take priority over all inputs; the following cycle: oResidual=0, oValid=0, oWarmup=0, oBestOrder=0, oBestValid=0, history=0, n=0, S0..S4=0.
REQ-029 Reset mid-frame SHALL discard frame state; a pending oBestValid SHALL NOT be issued.

Verification
REQ-030 Order 2, iFrameStart, samples 10,20,30,40,50 -> oResidual 10,20,0,0,0; oWarmup 1,1,0,0,0; each 1 cycle after input.
REQ-031 Order 4, samples 0,1,4,9,16,25 -> oResidual 0,1,4,9,0,0; oWarmup 1,1,1,1,0,0.
REQ-032 Order 4, alternating 32767,-32768,32767,-32768,32767 -> fifth oResidual = 524280 (no wrap).
REQ-033 10 samples of constant 100, iFrameEnd on the last -> S0=600, S1..S4=0; oBestOrder=1, oBestValid single pulse.
REQ-034 3 samples at order 1, iReset, then order 1 sample 7 -> all outputs 0 after reset; oResidual=7, oWarmup=1.
REQ-035 iFrameStart+iFrameEnd+iEnable on one cycle after a ramp frame -> oBestOrder from prior frame; current sample output verbatim, oWarmup=1 (order>=1).
